rename_map_unit: RTL and testbench

- Parametrised successor to the fixed 3-wide rename stage: WIDTH-wide register renaming with a speculative map table (RAT), a retirement map table (RRAT) and a bit-vector free list of physical tags.
- Sits between decode and dispatch.
- Allocates a physical tag per valid destination, resolves intra-group dependencies, frees tags on commit, and restores state on flush.
- Output is registered with valid/ready backpressure.

---
 rtl/rename_map_unit.sv | 263 ++++++++++++++++++++++++++
 tb/tb_rename_map_unit.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_map_unit.sv
// rename_map_unit
//   WIDTH-wide register rename stage between decode and dispatch. Keeps a
//   speculative map (RAT), a retirement map (RRAT) and a bit-vector free list
//   of physical tags. Each accepted group is renamed in one cycle and shows up
//   on the registered out_* bus the following cycle.
//
// Ports
//   clk, rst               clock; asynchronous active-low reset
//   in_valid / in_ready    rename group handshake
//   in_slot_valid, in_dst_en, in_dst, in_src0..2
//                          per-slot uop fields, 4-bit arch regs, slot i at [4i+3:4i]
//   out_valid / out_ready  renamed group handshake
//   out_slot_valid, out_dst_tag, out_old_tag, out_src0..2_tag
//                          registered renamed group, slot i at [TAG_W*i +: TAG_W]
//   commit_valid, commit_dst, commit_tag, commit_old_tag
//                          retirement updates, slot 0 oldest
//   flush                  restore RAT and free list from RRAT
//   free_count             popcount of the free list
module rename_map_unit #(
    parameter int WIDTH     = 3,
    parameter int COMMIT_W  = 3,
    parameter int ARCH_REGS = 15,
    parameter int PHYS_REGS = 48,
    parameter int TAG_W     = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_slot_valid,
    input  logic [WIDTH-1:0]          in_dst_en,
    input  logic [WIDTH*4-1:0]        in_dst,
    input  logic [WIDTH*4-1:0]        in_src0,
    input  logic [WIDTH*4-1:0]        in_src1,
    input  logic [WIDTH*4-1:0]        in_src2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_slot_valid,
    output logic [WIDTH*TAG_W-1:0]    out_dst_tag,
    output logic [WIDTH*TAG_W-1:0]    out_old_tag,
    output logic [WIDTH*TAG_W-1:0]    out_src0_tag,
    output logic [WIDTH*TAG_W-1:0]    out_src1_tag,
    output logic [WIDTH*TAG_W-1:0]    out_src2_tag,
    input  logic [COMMIT_W-1:0]       commit_valid,
    input  logic [COMMIT_W*4-1:0]     commit_dst,
    input  logic [COMMIT_W*TAG_W-1:0] commit_tag,
    input  logic [COMMIT_W*TAG_W-1:0] commit_old_tag,
    input  logic                      flush,
    output logic [TAG_W:0]            free_count
);

    localparam int CNT_W = TAG_W + 1;
    localparam logic [4:0]           ARCH_LIM = 5'(ARCH_REGS);
    localparam logic [TAG_W:0]       PHYS_LIM = CNT_W'(PHYS_REGS);
    localparam logic [PHYS_REGS-1:0] FREE_RST = {PHYS_REGS{1'b1}} << ARCH_REGS;

    typedef logic [TAG_W-1:0] tag_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    tag_t                   rat_q  [ARCH_REGS];
    tag_t                   rat_d  [ARCH_REGS];
    tag_t                   rrat_q [ARCH_REGS];
    tag_t                   rrat_d [ARCH_REGS];
    logic [PHYS_REGS-1:0]   free_q, free_d;
    logic                   out_valid_q, out_valid_d;
    logic [WIDTH-1:0]       out_slot_valid_q, out_slot_valid_d;
    logic [WIDTH*TAG_W-1:0] out_dst_tag_q, out_dst_tag_d;
    logic [WIDTH*TAG_W-1:0] out_old_tag_q, out_old_tag_d;
    logic [WIDTH*TAG_W-1:0] out_src0_tag_q, out_src0_tag_d;
    logic [WIDTH*TAG_W-1:0] out_src1_tag_q, out_src1_tag_d;
    logic [WIDTH*TAG_W-1:0] out_src2_tag_q, out_src2_tag_d;

    function automatic logic is_arch(input logic [3:0] r);
        return {1'b0, r} < ARCH_LIM;
    endfunction

    // ------------------------------------------------------------------
    // Free count and input handshake
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] free_cnt;

    always_comb begin
        free_cnt = '0;
        for (int p = 0; p < PHYS_REGS; p++) begin
            free_cnt = free_cnt + CNT_W'(free_q[p]);
        end
    end

    assign free_count = free_cnt;

    // Conservative: a full WIDTH tags must be free regardless of dst_en.
    assign in_ready = rst && !flush && (!out_valid_q || out_ready)
                      && (free_cnt >= CNT_W'(WIDTH));

    logic accept;
    assign accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Rename: walk slots in order over a working copy of the RAT so that a
    // later slot naturally sees the youngest earlier slot's new mapping
    // (covers both source bypass and old-tag bypass).
    // ------------------------------------------------------------------
    tag_t                   rat_w [ARCH_REGS];
    logic [PHYS_REGS-1:0]   avail;
    logic [PHYS_REGS-1:0]   alloc_mask;
    logic [WIDTH*TAG_W-1:0] ren_dst, ren_old, ren_s0, ren_s1, ren_s2;
    logic [3:0]             sd, ss0, ss1, ss2;
    tag_t                   pick;
    logic                   found;

    always_comb begin
        rat_w      = rat_q;
        avail      = free_q;
        alloc_mask = '0;
        ren_dst    = '0;
        ren_old    = '0;
        ren_s0     = '0;
        ren_s1     = '0;
        ren_s2     = '0;
        sd         = '0;
        ss0        = '0;
        ss1        = '0;
        ss2        = '0;
        pick       = '0;
        found      = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            sd  = in_dst[4*k +: 4];
            ss0 = in_src0[4*k +: 4];
            ss1 = in_src1[4*k +: 4];
            ss2 = in_src2[4*k +: 4];
            // Sources read before this slot's own dst update.
            ren_s0[k*TAG_W +: TAG_W] = is_arch(ss0) ? rat_w[ss0] : '1;
            ren_s1[k*TAG_W +: TAG_W] = is_arch(ss1) ? rat_w[ss1] : '1;
            ren_s2[k*TAG_W +: TAG_W] = is_arch(ss2) ? rat_w[ss2] : '1;
            if (in_slot_valid[k] && in_dst_en[k] && is_arch(sd)) begin
                // Lowest remaining free bit; earlier slots already removed theirs.
                pick  = '0;
                found = 1'b0;
                for (int p = 0; p < PHYS_REGS; p++) begin
                    if (!found && avail[p]) begin
                        pick  = TAG_W'(p);
                        found = 1'b1;
                    end
                end
                avail[pick]              = 1'b0;
                alloc_mask[pick]         = 1'b1;
                ren_dst[k*TAG_W +: TAG_W] = pick;
                ren_old[k*TAG_W +: TAG_W] = rat_w[sd];
                rat_w[sd]                = pick;
            end
        end
    end

    // ------------------------------------------------------------------
    // Commit: younger slots overwrite older ones on equal dst.
    // ------------------------------------------------------------------
    tag_t                 rrat_w [ARCH_REGS];
    logic [PHYS_REGS-1:0] commit_free;
    logic [3:0]           cd;
    tag_t                 ct, co;

    always_comb begin
        rrat_w      = rrat_q;
        commit_free = '0;
        cd          = '0;
        ct          = '0;
        co          = '0;
        for (int c = 0; c < COMMIT_W; c++) begin
            cd = commit_dst[4*c +: 4];
            ct = commit_tag[c*TAG_W +: TAG_W];
            co = commit_old_tag[c*TAG_W +: TAG_W];
            if (commit_valid[c] && is_arch(cd)) begin
                rrat_w[cd] = ct;
                if ({1'b0, co} < PHYS_LIM) begin
                    commit_free[co] = 1'b1;
                end
            end
        end
    end

    // Tags referenced by the post-commit RRAT; everything else is free on flush.
    logic [PHYS_REGS-1:0] rrat_used;

    always_comb begin
        rrat_used = '0;
        for (int a = 0; a < ARCH_REGS; a++) begin
            if ({1'b0, rrat_w[a]} < PHYS_LIM) begin
                rrat_used[rrat_w[a]] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        rrat_d = rrat_w;
        if (flush) begin
            rat_d  = rrat_w;
            free_d = ~rrat_used;
        end else begin
            rat_d  = accept ? rat_w : rat_q;
            free_d = (free_q & ~(accept ? alloc_mask : '0)) | commit_free;
        end

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        // Data only moves on accept; otherwise it holds (stall or drained).
        out_slot_valid_d = accept ? in_slot_valid : out_slot_valid_q;
        out_dst_tag_d    = accept ? ren_dst       : out_dst_tag_q;
        out_old_tag_d    = accept ? ren_old       : out_old_tag_q;
        out_src0_tag_d   = accept ? ren_s0        : out_src0_tag_q;
        out_src1_tag_d   = accept ? ren_s1        : out_src1_tag_q;
        out_src2_tag_d   = accept ? ren_s2        : out_src2_tag_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat_q[i]  <= TAG_W'(i);
                rrat_q[i] <= TAG_W'(i);
            end
            free_q           <= FREE_RST;
            out_valid_q      <= 1'b0;
            out_slot_valid_q <= '0;
            out_dst_tag_q    <= '0;
            out_old_tag_q    <= '0;
            out_src0_tag_q   <= '0;
            out_src1_tag_q   <= '0;
            out_src2_tag_q   <= '0;
        end else begin
            rat_q            <= rat_d;
            rrat_q           <= rrat_d;
            free_q           <= free_d;
            out_valid_q      <= out_valid_d;
            out_slot_valid_q <= out_slot_valid_d;
            out_dst_tag_q    <= out_dst_tag_d;
            out_old_tag_q    <= out_old_tag_d;
            out_src0_tag_q   <= out_src0_tag_d;
            out_src1_tag_q   <= out_src1_tag_d;
            out_src2_tag_q   <= out_src2_tag_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_slot_valid = out_slot_valid_q;
    assign out_dst_tag    = out_dst_tag_q;
    assign out_old_tag    = out_old_tag_q;
    assign out_src0_tag   = out_src0_tag_q;
    assign out_src1_tag   = out_src1_tag_q;
    assign out_src2_tag   = out_src2_tag_q;

endmodule

// File: tb/tb_rename_map_unit.sv
// Randomized bench for rename_map_unit. A reference model of the map tables
// and free list (plain int/bit arrays) predicts each accepted group; the
// expected group is queued and a separate monitor compares it against the
// output bus whenever out_valid is high.
module tb_rename_map_unit;

    localparam int W  = 3;
    localparam int CW = 3;
    localparam int AR = 15;
    localparam int PR = 48;
    localparam int TW = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    in_slot_valid = '0;
    logic [W-1:0]    in_dst_en = '0;
    logic [W*4-1:0]  in_dst = '0, in_src0 = '0, in_src1 = '0, in_src2 = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [W-1:0]    out_slot_valid;
    logic [W*TW-1:0] out_dst_tag, out_old_tag, out_src0_tag, out_src1_tag, out_src2_tag;
    logic [CW-1:0]   commit_valid = '0;
    logic [CW*4-1:0] commit_dst = '0;
    logic [CW*TW-1:0] commit_tag = '0, commit_old_tag = '0;
    logic            flush = 1'b0;
    logic [TW:0]     free_count;

    rename_map_unit #(.WIDTH(W), .COMMIT_W(CW), .ARCH_REGS(AR), .PHYS_REGS(PR), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_slot_valid(in_slot_valid), .in_dst_en(in_dst_en), .in_dst(in_dst),
        .in_src0(in_src0), .in_src1(in_src1), .in_src2(in_src2),
        .out_valid(out_valid), .out_ready(out_ready), .out_slot_valid(out_slot_valid),
        .out_dst_tag(out_dst_tag), .out_old_tag(out_old_tag),
        .out_src0_tag(out_src0_tag), .out_src1_tag(out_src1_tag), .out_src2_tag(out_src2_tag),
        .commit_valid(commit_valid), .commit_dst(commit_dst), .commit_tag(commit_tag),
        .commit_old_tag(commit_old_tag), .flush(flush), .free_count(free_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]    sv;
        logic [W*TW-1:0] dt, ot, s0, s1, s2;
    } exp_t;

    typedef struct {
        int d, nt, ot;
    } fl_t;

    // Reference model state
    int   rat_m [AR];
    int   rrat_m[AR];
    bit   free_m[PR];
    bit   ov_m;
    exp_t exp_q[$];
    fl_t  fl_q[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int popcnt();
        int n = 0;
        foreach (free_m[p]) n += int'(free_m[p]);
        return n;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < AR; i++) begin
            rat_m[i]  = i;
            rrat_m[i] = i;
        end
        for (int p = 0; p < PR; p++) free_m[p] = (p >= AR);
        ov_m = 1'b0;
    endfunction

    function automatic int tsrc(input int s, input int work[AR]);
        return (s >= AR) ? ((1 << TW) - 1) : work[s];
    endfunction

    task automatic drive_idle();
        in_valid = 1'b0; in_slot_valid = '0; in_dst_en = '0;
        in_dst = '0; in_src0 = '0; in_src1 = '0; in_src2 = '0;
        commit_valid = '0; commit_dst = '0; commit_tag = '0; commit_old_tag = '0;
        flush = 1'b0; out_ready = 1'b1;
    endtask

    // Commits come from the in-flight list in program order so the model
    // state stays meaningful; the odd commit to r15 must be ignored.
    task automatic drive_random(input int p_in, input int p_commit, input int p_flush,
                                input int p_ordy, input bit full);
        fl_t f;
        in_valid = full ? 1'b1 : ($urandom % 100 < p_in);
        for (int k = 0; k < W; k++) begin
            in_slot_valid[k] = full ? 1'b1 : ($urandom % 4 != 0);
            in_dst_en[k]     = full ? 1'b1 : ($urandom % 4 != 0);
            in_dst[4*k +: 4]  = full ? 4'($urandom_range(0, AR - 1)) : 4'($urandom_range(0, 15));
            in_src0[4*k +: 4] = 4'($urandom_range(0, 15));
            in_src1[4*k +: 4] = 4'($urandom_range(0, 15));
            in_src2[4*k +: 4] = 4'($urandom_range(0, 15));
        end
        commit_valid = '0; commit_dst = '0; commit_tag = '0; commit_old_tag = '0;
        for (int c = 0; c < CW; c++) begin
            if ($urandom % 100 < p_commit && fl_q.size() > 0) begin
                f = fl_q.pop_front();
                commit_valid[c] = 1'b1;
                commit_dst[4*c +: 4]       = 4'(f.d);
                commit_tag[c*TW +: TW]     = TW'(f.nt);
                commit_old_tag[c*TW +: TW] = TW'(f.ot);
            end else if (p_commit > 0 && $urandom % 16 == 0) begin
                commit_valid[c] = 1'b1;
                commit_dst[4*c +: 4]       = 4'd15;
                commit_tag[c*TW +: TW]     = TW'($urandom_range(0, PR - 1));
                commit_old_tag[c*TW +: TW] = TW'($urandom_range(0, PR - 1));
            end
        end
        flush     = ($urandom % 100 < p_flush);
        out_ready = ($urandom % 100 < p_ordy);
    endtask

    // Compare handshake/count outputs, then advance the model one clock.
    task automatic eval_cycle();
        int   work[AR];
        bit   avail[PR];
        int   freed[$];
        fl_t  newf[$];
        exp_t e;
        bit   ready_m, acc;
        int   nf, d, p;
        #1;
        nf      = popcnt();
        ready_m = !flush && (!ov_m || out_ready) && nf >= W;
        check("in_ready", 64'(in_ready), 64'(ready_m));
        check("out_valid", 64'(out_valid), 64'(ov_m));
        check("free_count", 64'(free_count), 64'(nf));
        acc   = in_valid && ready_m;
        work  = rat_m;
        avail = free_m;
        e     = '0;
        if (acc) begin
            for (int k = 0; k < W; k++) begin
                e.sv[k] = in_slot_valid[k];
                e.s0[k*TW +: TW] = TW'(tsrc(int'(in_src0[4*k +: 4]), work));
                e.s1[k*TW +: TW] = TW'(tsrc(int'(in_src1[4*k +: 4]), work));
                e.s2[k*TW +: TW] = TW'(tsrc(int'(in_src2[4*k +: 4]), work));
                d = int'(in_dst[4*k +: 4]);
                if (in_slot_valid[k] && in_dst_en[k] && d < AR) begin
                    p = 0;
                    while (p < PR && !avail[p]) p++;
                    avail[p] = 1'b0;
                    e.dt[k*TW +: TW] = TW'(p);
                    e.ot[k*TW +: TW] = TW'(work[d]);
                    newf.push_back('{d, p, work[d]});
                    work[d] = p;
                end
            end
        end
        for (int c = 0; c < CW; c++) begin
            if (commit_valid[c] && int'(commit_dst[4*c +: 4]) < AR) begin
                rrat_m[int'(commit_dst[4*c +: 4])] = int'(commit_tag[c*TW +: TW]);
                if (int'(commit_old_tag[c*TW +: TW]) < PR) freed.push_back(int'(commit_old_tag[c*TW +: TW]));
            end
        end
        if (flush) begin
            rat_m = rrat_m;
            for (int q = 0; q < PR; q++) free_m[q] = 1'b1;
            for (int a = 0; a < AR; a++) if (rrat_m[a] < PR) free_m[rrat_m[a]] = 1'b0;
            ov_m = 1'b0;
            fl_q.delete();
        end else begin
            if (acc) begin
                rat_m  = work;
                free_m = avail;
                exp_q.push_back(e);
                foreach (newf[i]) fl_q.push_back(newf[i]);
            end
            foreach (freed[i]) free_m[freed[i]] = 1'b1;
            ov_m = acc ? 1'b1 : (out_ready ? 1'b0 : ov_m);
        end
        @(posedge clk);
        if (flush) exp_q.delete();
    endtask

    task automatic step(input int p_in, input int p_commit, input int p_flush,
                        input int p_ordy, input bit full);
        @(negedge clk);
        drive_random(p_in, p_commit, p_flush, p_ordy, full);
        eval_cycle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_free_count", 64'(free_count), 64'(PR - AR));
        check("rst_out_tags", 64'({out_dst_tag, out_old_tag, out_slot_valid}), 64'd0);
        model_reset();
        exp_q.delete();
        fl_q.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: compare whatever the DUT presents against the queue head.
    initial begin
        exp_t e;
        logic [W*TW-1:0] m;
        forever begin
            @(negedge clk);
            #2;
            if (rst && out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = exp_q[0];
                    m = '0;
                    for (int k = 0; k < W; k++) if (e.sv[k]) m[k*TW +: TW] = '1;
                    check("slot_valid", 64'(out_slot_valid), 64'(e.sv));
                    check("dst_tag", 64'(out_dst_tag), 64'(e.dt));
                    check("old_tag", 64'(out_old_tag), 64'(e.ot));
                    check("src0_tag", 64'(out_src0_tag & m), 64'(e.s0 & m));
                    check("src1_tag", 64'(out_src1_tag & m), 64'(e.s1 & m));
                    check("src2_tag", 64'(out_src2_tag & m), 64'(e.s2 & m));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        model_reset();
        do_reset();

        // Directed group: r1<-r2,r3 ; r2<-r1 ; r1<-r1
        @(negedge clk);
        drive_idle();
        in_valid = 1'b1; in_slot_valid = 3'b111; in_dst_en = 3'b111;
        in_dst  = {4'd1, 4'd2, 4'd1};
        in_src0 = {4'd1, 4'd1, 4'd2};
        in_src1 = {4'd0, 4'd0, 4'd3};
        eval_cycle();
        @(negedge clk);
        drive_idle();
        out_ready = 1'b0;
        #1;
        check("tp_dst_tags", 64'(out_dst_tag), 64'({6'd17, 6'd16, 6'd15}));
        check("tp_src0_tags", 64'(out_src0_tag), 64'({6'd15, 6'd15, 6'd2}));
        check("tp_free_count", 64'(free_count), 64'd30);
        eval_cycle();
        // Stall a second cycle, then release.
        step(100, 0, 0, 0, 1'b1);
        step(0, 0, 0, 100, 1'b0);
        step(0, 0, 0, 100, 1'b0);

        // Exhaust the free list: 11 full groups, no commits.
        do_reset();
        for (int g = 0; g < 11; g++) step(100, 0, 0, 100, 1'b1);
        @(negedge clk);
        drive_idle();
        in_valid = 1'b1;
        #1;
        check("exhaust_free_count", 64'(free_count), 64'd0);
        check("exhaust_in_ready", 64'(in_ready), 64'd0);
        eval_cycle();
        step(0, 100, 0, 100, 1'b0);
        @(negedge clk);
        drive_idle();
        #1;
        check("refill_free_count", 64'(free_count), 64'd3);
        check("refill_in_ready", 64'(in_ready), 64'd1);
        eval_cycle();

        // Two commits to r4 in one cycle, plus flush.
        do_reset();
        @(negedge clk);
        drive_idle();
        commit_valid = 3'b011;
        commit_dst = {4'd0, 4'd4, 4'd4};
        commit_tag = {6'd0, 6'd22, 6'd20};
        commit_old_tag = {6'd0, 6'd20, 6'd4};
        flush = 1'b1;
        eval_cycle();
        @(negedge clk);
        drive_idle();
        in_valid = 1'b1; in_slot_valid = 3'b001; in_dst_en = 3'b001;
        in_dst = {4'd0, 4'd0, 4'd5}; in_src0 = {4'd0, 4'd0, 4'd4};
        eval_cycle();
        @(negedge clk);
        drive_idle();
        #1;
        check("flush_rat4", 64'(out_src0_tag[TW-1:0]), 64'd22);
        check("flush_alloc4", 64'(out_dst_tag[TW-1:0]), 64'd4);
        eval_cycle();

        // Random traffic.
        for (int i = 0; i < 2000; i++) step(70, 40, 3, 70, 1'b0);

        // Reset while a group is stalled on the output.
        do_reset();
        for (int i = 0; i < 3; i++) step(100, 0, 0, 0, 1'b1);
        @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_free_count", 64'(free_count), 64'(PR - AR));
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_dst_tag", 64'(out_dst_tag), 64'd0);
        model_reset();
        exp_q.delete();
        fl_q.delete();
        @(negedge clk);
        drive_idle();
        rst = 1'b1;

        for (int i = 0; i < 500; i++) step(70, 40, 3, 70, 1'b0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
